// File: rtl/hs_pkg.sv
// Shared state encodings for the req/ack pipeline FIFO.
package hs_pkg;

    // Upstream (accept) side handshake state
    typedef enum logic [0:0] {
        I_IDLE = 1'b0,
        I_ACK  = 1'b1
    } in_state_t;

    // Downstream (offer) side handshake state
    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_REQ  = 2'd1,
        O_RTZ  = 2'd2
    } out_state_t;

endpackage : hs_pkg

// File: rtl/hs_sync.sv
// Single-bit flop chain for handshake lines arriving from another timing domain.
module hs_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift d through STAGES flops, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule : hs_sync

// File: rtl/hs_fifo_pipe.sv
// Four-phase req/ack buffer: upstream handshake writes a DEPTH-entry FIFO,
// downstream handshake offers entries in order. Occupancy reported on level/full/empty.
module hs_fifo_pipe
    import hs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_in,
    output logic                           ack_out,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic                           req_out,
    input  logic                           ack_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic req_s;
    logic ack_s;

    // Optional synchronisers on the incoming handshake lines
    if (SYNC_STAGES == 0) begin : g_direct
        assign req_s = req_in;
        assign ack_s = ack_in;
    end else begin : g_sync
        hs_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req_in),
            .q     (req_s)
        );
        hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (ack_in),
            .q     (ack_s)
        );
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    in_state_t             in_state,  in_state_n;
    out_state_t            out_state, out_state_n;
    logic [PTR_W-1:0]      wr_ptr,    wr_ptr_n;
    logic [PTR_W-1:0]      rd_ptr,    rd_ptr_n;
    logic [LVL_W-1:0]      level_n;
    logic                  ack_out_n;
    logic                  req_out_n;
    logic [DATA_WIDTH-1:0] data_out_n;
    logic                  full_n;
    logic                  empty_n;
    logic                  wr_en;
    logic                  pop;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state and next-output decode for both handshake sides and occupancy
    always_comb begin
        in_state_n  = in_state;
        out_state_n = out_state;
        ack_out_n   = ack_out;
        req_out_n   = req_out;
        data_out_n  = data_out;
        wr_en       = 1'b0;
        pop         = 1'b0;

        unique case (in_state)
            I_IDLE: begin
                // full is the registered flag: a pop on this edge cannot make room
                if (req_s && !full) begin
                    wr_en      = 1'b1;
                    ack_out_n  = 1'b1;
                    in_state_n = I_ACK;
                end
            end
            I_ACK: begin
                if (!req_s) begin
                    ack_out_n  = 1'b0;
                    in_state_n = I_IDLE;
                end
            end
            default: in_state_n = I_IDLE;
        endcase

        unique case (out_state)
            O_IDLE: begin
                // a stale ack_s from the consumer holds off the next offer
                if (!empty && !ack_s) begin
                    data_out_n  = mem[rd_ptr];
                    req_out_n   = 1'b1;
                    out_state_n = O_REQ;
                end
            end
            O_REQ: begin
                if (ack_s) begin
                    req_out_n   = 1'b0;
                    pop         = 1'b1;
                    out_state_n = O_RTZ;
                end
            end
            O_RTZ: begin
                if (!ack_s) begin
                    out_state_n = O_IDLE;
                end
            end
            default: out_state_n = O_IDLE;
        endcase

        wr_ptr_n = wr_en ? inc_ptr(wr_ptr) : wr_ptr;
        rd_ptr_n = pop   ? inc_ptr(rd_ptr) : rd_ptr;

        unique case ({wr_en, pop})
            2'b10:   level_n = level + LVL_W'(1);
            2'b01:   level_n = level - LVL_W'(1);
            default: level_n = level;
        endcase

        full_n  = (level_n == LVL_W'(DEPTH));
        empty_n = (level_n == '0);
    end

    // State, pointer, status and handshake output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state  <= I_IDLE;
            out_state <= O_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            ack_out   <= 1'b0;
            req_out   <= 1'b0;
            data_out  <= '0;
        end else begin
            in_state  <= in_state_n;
            out_state <= out_state_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            level     <= level_n;
            full      <= full_n;
            empty     <= empty_n;
            ack_out   <= ack_out_n;
            req_out   <= req_out_n;
            data_out  <= data_out_n;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule : hs_fifo_pipe

// File: tb/tb_hs_fifo_pipe.sv
// Bench for hs_fifo_pipe: directed handshake scenarios plus random traffic
// against an in-order word queue and an event-count occupancy model.
module tb_hs_fifo_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // index 0: DEPTH=4, SYNC_STAGES=0   index 1: DEPTH=3, SYNC_STAGES=2
    logic       req_in_v  [2];
    logic       ack_in_v  [2];
    logic [2:0] data_in_v [2];
    logic       ack_out_v [2];
    logic       req_out_v [2];
    logic       full_v    [2];
    logic       empty_v   [2];
    logic [2:0] data_out_v[2];

    logic       ack_out_a, req_out_a, full_a, empty_a;
    logic       ack_out_b, req_out_b, full_b, empty_b;
    logic [2:0] data_out_a, data_out_b;
    logic [2:0] level_a;
    logic [1:0] level_b;

    int n_checks = 0;
    int n_errors = 0;

    hs_fifo_pipe #(.DATA_WIDTH(3), .DEPTH(4), .SYNC_STAGES(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_in(req_in_v[0]), .ack_out(ack_out_a), .data_in(data_in_v[0]),
        .req_out(req_out_a), .ack_in(ack_in_v[0]), .data_out(data_out_a),
        .level(level_a), .full(full_a), .empty(empty_a)
    );

    hs_fifo_pipe #(.DATA_WIDTH(3), .DEPTH(3), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_in(req_in_v[1]), .ack_out(ack_out_b), .data_in(data_in_v[1]),
        .req_out(req_out_b), .ack_in(ack_in_v[1]), .data_out(data_out_b),
        .level(level_b), .full(full_b), .empty(empty_b)
    );

    assign ack_out_v[0]  = ack_out_a;   assign ack_out_v[1]  = ack_out_b;
    assign req_out_v[0]  = req_out_a;   assign req_out_v[1]  = req_out_b;
    assign full_v[0]     = full_a;      assign full_v[1]     = full_b;
    assign empty_v[0]    = empty_a;     assign empty_v[1]    = empty_b;
    assign data_out_v[0] = data_out_a;  assign data_out_v[1] = data_out_b;

    function automatic int lvl(input int d);
        return (d == 0) ? int'(level_a) : int'(level_b);
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // Packed view {ack_out, req_out, data_out, level, full, empty}
    function automatic logic [9:0] snap(input int d);
        return {ack_out_v[d], req_out_v[d], data_out_v[d], 3'(lvl(d)), full_v[d], empty_v[d]};
    endfunction

    function automatic logic [9:0] mk(input logic a, input logic r, input logic [2:0] dat,
                                      input int l, input logic f, input logic e);
        return {a, r, dat, 3'(l), f, e};
    endfunction

    // Upstream handshake for one word; ok=0 if any phase times out
    task automatic push_word(input int d, input logic [2:0] v, output bit ok);
        bit low_ok = 1'b0;
        ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (ack_out_v[d] === 1'b0) begin low_ok = 1'b1; break; end
            @(negedge clk);
        end
        data_in_v[d] = v;
        req_in_v[d]  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack_out_v[d] === 1'b1) begin ok = low_ok; break; end
        end
        req_in_v[d] = 1'b0;
    endtask

    // Downstream handshake for one word
    task automatic pop_word(input int d, output logic [2:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_out_v[d] === 1'b1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            v = data_out_v[d];
            ack_in_v[d] = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (req_out_v[d] === 1'b0) begin ok = 1'b1; break; end
            end
            ack_in_v[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_in_v[d] = 1'b0; ack_in_v[d] = 1'b0; data_in_v[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (snap(d) !== mk(0, 0, 3'd0, 0, 0, 1)) begin
                n_errors++;
                $display("FAIL reset_state dut%0d got=%b exp=%b", d, snap(d), mk(0, 0, 3'd0, 0, 0, 1));
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [9:0] exp_s [3];
        exp_s[0] = mk(1, 0, 3'd0, 1, 0, 0);
        exp_s[1] = mk(1, 1, 3'd5, 1, 0, 0);
        exp_s[2] = mk(0, 0, 3'd5, 0, 0, 1);
        data_in_v[0] = 3'd5;
        req_in_v[0]  = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            n_checks++;
            if (snap(0) !== exp_s[e]) begin
                n_errors++;
                $display("FAIL single_edge%0d got=%b exp=%b", e + 1, snap(0), exp_s[e]);
            end
            if (e == 1) begin
                req_in_v[0] = 1'b0;
                ack_in_v[0] = 1'b1;
            end
        end
        ack_in_v[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fill();
        bit ok;
        bit stall_bad = 1'b0;
        logic [2:0] v;
        for (int k = 1; k <= 4; k++) begin
            push_word(0, 3'(k), ok);
            n_checks++;
            if (!ok) begin n_errors++; $display("FAIL fill_push%0d got=timeout exp=ack", k); end
        end
        n_checks++;
        if (snap(0) !== mk(1, 1, 3'd1, 4, 1, 0)) begin
            n_errors++;
            $display("FAIL fill_full got=%b exp=%b", snap(0), mk(1, 1, 3'd1, 4, 1, 0));
        end
        for (int i = 0; i < 10 && ack_out_v[0] !== 1'b0; i++) @(negedge clk);
        data_in_v[0] = 3'd5;
        req_in_v[0]  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ack_out_v[0] !== 1'b0 || full_v[0] !== 1'b1) stall_bad = 1'b1;
        end
        n_checks++;
        if (stall_bad) begin n_errors++; $display("FAIL fill_stall got=accepted exp=stalled"); end
        ack_in_v[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (snap(0) !== mk(0, 0, 3'd1, 3, 0, 0)) begin
            n_errors++;
            $display("FAIL fill_pop_edge got=%b exp=%b", snap(0), mk(0, 0, 3'd1, 3, 0, 0));
        end
        @(negedge clk);
        n_checks++;
        if (snap(0) !== mk(1, 0, 3'd1, 4, 1, 0)) begin
            n_errors++;
            $display("FAIL fill_accept5 got=%b exp=%b", snap(0), mk(1, 0, 3'd1, 4, 1, 0));
        end
        req_in_v[0] = 1'b0;
        ack_in_v[0] = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            pop_word(0, v, ok);
            n_checks++;
            if (!ok || v !== 3'(k)) begin
                n_errors++;
                $display("FAIL fill_order got=%0d ok=%0d exp=%0d", v, ok, k);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [2:0] v;
        logic [2:0] q[$];
        for (int lv = 1; lv <= 3; lv++) begin
            q.delete();
            for (int k = 0; k < lv; k++) begin
                v = 3'(lv * 3 + k);
                q.push_back(v);
                push_word(0, v, ok);
            end
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (ack_out_v[0] === 1'b0 && req_out_v[0] === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            n_checks++;
            if (!ok) begin n_errors++; $display("FAIL simul_setup lv=%0d got=timeout exp=offer", lv); end
            data_in_v[0] = 3'd7;
            req_in_v[0]  = 1'b1;
            ack_in_v[0]  = 1'b1;
            @(negedge clk);
            n_checks++;
            if (snap(0) !== mk(1, 0, q[0], lv, 0, 0)) begin
                n_errors++;
                $display("FAIL simul_level lv=%0d got=%b exp=%b", lv, snap(0), mk(1, 0, q[0], lv, 0, 0));
            end
            req_in_v[0] = 1'b0;
            ack_in_v[0] = 1'b0;
            void'(q.pop_front());
            q.push_back(3'd7);
            for (int k = 0; k < lv; k++) begin
                pop_word(0, v, ok);
                n_checks++;
                if (!ok || v !== q[k]) begin
                    n_errors++;
                    $display("FAIL simul_drain lv=%0d got=%0d exp=%0d", lv, v, q[k]);
                end
            end
            n_checks++;
            if ({empty_v[0], level_a} !== {1'b1, 3'd0}) begin
                n_errors++;
                $display("FAIL simul_empty lv=%0d got=%b exp=1000", lv, {empty_v[0], level_a});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        push_word(0, 3'd3, ok);
        push_word(0, 3'd6, ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_out_v[0] === 1'b1 && level_a == 3'd2) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL rstmid_setup got=timeout exp=two_words"); end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (snap(d) !== mk(0, 0, 3'd0, 0, 0, 1)) begin
                n_errors++;
                $display("FAIL rstmid_state dut%0d got=%b exp=%b", d, snap(d), mk(0, 0, 3'd0, 0, 0, 1));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sync();
        logic [9:0] exp_s [4];
        exp_s[0] = mk(0, 0, 3'd0, 0, 0, 1);
        exp_s[1] = mk(0, 0, 3'd0, 0, 0, 1);
        exp_s[2] = mk(1, 0, 3'd0, 1, 0, 0);
        exp_s[3] = mk(1, 1, 3'd6, 1, 0, 0);
        data_in_v[1] = 3'd6;
        req_in_v[1]  = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            n_checks++;
            if (snap(1) !== exp_s[e]) begin
                n_errors++;
                $display("FAIL sync_edge%0d got=%b exp=%b", e + 1, snap(1), exp_s[e]);
            end
        end
        req_in_v[1] = 1'b0;
    endtask

    task automatic test_withhold();
        bit ok;
        logic [2:0] v;
        push_word(1, 3'd7, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL hold_push got=timeout exp=ack"); end
        ack_in_v[1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_out_v[1] === 1'b0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL hold_first_pop got=timeout exp=req_low"); end
        // one-cycle ack gap lets the output side return to idle with ack still high
        ack_in_v[1] = 1'b0;
        @(negedge clk);
        ack_in_v[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({req_out_v[1], level_b} !== {1'b0, 2'd1}) begin
                n_errors++;
                $display("FAIL hold_withheld cyc%0d got=%b exp=001", i, {req_out_v[1], level_b});
            end
        end
        ack_in_v[1] = 1'b0;
        pop_word(1, v, ok);
        n_checks++;
        if (!ok || v !== 3'd7) begin n_errors++; $display("FAIL hold_release got=%0d ok=%0d exp=7", v, ok); end
        repeat (4) @(negedge clk);
        n_checks++;
        if ({empty_v[1], level_b} !== {1'b1, 2'd0}) begin
            n_errors++;
            $display("FAIL hold_empty got=%b exp=100", {empty_v[1], level_b});
        end
    endtask

    // Random producer/consumer; model: ordered word queue, level = accepts - pops
    task automatic test_random(input int d, input int n);
        logic [2:0] exp_q[$];
        logic [2:0] v;
        int sent = 0, recv = 0, wr = 0, pops = 0, pp = 0, cp = 0, mlev;
        bit done = 1'b0, slow;
        logic prev_ack = ack_out_v[d];
        logic prev_req = req_out_v[d];
        logic [2:0] prev_dat = data_out_v[d];
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (ack_out_v[d] && !prev_ack) wr++;
            if (!req_out_v[d] && prev_req) pops++;
            mlev = wr - pops;
            n_checks++;
            if (lvl(d) != mlev || mlev > depth_of(d) ||
                {full_v[d], empty_v[d]} !== {mlev == depth_of(d), mlev == 0}) begin
                n_errors++;
                $display("FAIL rand%0d_level cyc%0d got=%0d f=%b e=%b exp=%0d", d, cyc,
                         lvl(d), full_v[d], empty_v[d], mlev);
            end
            if (req_out_v[d] && !prev_req) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rand%0d_data got=%0d exp=none", d, data_out_v[d]);
                end else begin
                    v = exp_q.pop_front();
                    if (data_out_v[d] !== v) begin
                        n_errors++;
                        $display("FAIL rand%0d_data got=%0d exp=%0d", d, data_out_v[d], v);
                    end
                end
                recv++;
            end else if (req_out_v[d] && prev_req && data_out_v[d] !== prev_dat) begin
                n_checks++;
                n_errors++;
                $display("FAIL rand%0d_stable got=%0d exp=%0d", d, data_out_v[d], prev_dat);
            end
            prev_ack = ack_out_v[d];
            prev_req = req_out_v[d];
            prev_dat = data_out_v[d];
            if (recv == n && sent == n && pp == 0 && cp == 0 && !ack_out_v[d] && !req_out_v[d]) begin
                done = 1'b1;
                break;
            end
            case (pp)
                0: if (sent < n && $urandom_range(0, 1) == 1) begin
                       v = 3'($urandom_range(0, 7));
                       data_in_v[d] = v;
                       req_in_v[d]  = 1'b1;
                       exp_q.push_back(v);
                       sent++;
                       pp = 1;
                   end
                1: if (ack_out_v[d] && $urandom_range(0, 2) != 0) begin
                       req_in_v[d] = 1'b0;
                       pp = 2;
                   end
                default: if (!ack_out_v[d]) pp = 0;
            endcase
            slow = ((cyc / 150) % 2) == 0;
            case (cp)
                0: if (req_out_v[d] && (slow ? $urandom_range(0, 5) == 0 : $urandom_range(0, 1) == 1)) begin
                       ack_in_v[d] = 1'b1;
                       cp = 1;
                   end
                default: if (!req_out_v[d] && $urandom_range(0, 1) == 1) begin
                       ack_in_v[d] = 1'b0;
                       cp = 0;
                   end
            endcase
        end
        n_checks++;
        if (!done || recv != n) begin
            n_errors++;
            $display("FAIL rand%0d_complete got=%0d exp=%0d done=%0d", d, recv, n, done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simultaneous();
        test_reset_mid();
        test_sync();
        test_withhold();
        test_random(0, 40);
        test_random(1, 40);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_hs_fifo_pipe
